// File: rtl/ncpu32k_wb_arbiter.sv
// ncpu32k_wb_arbiter: write-back arbiter and sole driver of the regfile write port.
// Grants at most one of ALU (0), LSU (1) or MUL/DIV (2) per cycle and registers the
// winner onto the regfile write port, which doubles as the write-back forwarding source.
// Build option: define NCPU_WB_RR_EN for round-robin arbitration; otherwise fixed
// priority LSU > MDU > ALU. NCPU_REG_AW / NCPU_DW provide the default widths.

`ifndef NCPU_REG_AW
`define NCPU_REG_AW 5
`endif
`ifndef NCPU_DW
`define NCPU_DW 32
`endif

module ncpu32k_wb_arbiter #(
    parameter int unsigned AW = `NCPU_REG_AW,
    parameter int unsigned DW = `NCPU_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          alu_valid,
    input  logic          lsu_valid,
    input  logic          mdu_valid,
    output logic          alu_ready,
    output logic          lsu_ready,
    output logic          mdu_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [AW-1:0] lsu_addr,
    input  logic [AW-1:0] mdu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic [DW-1:0] lsu_data,
    input  logic [DW-1:0] mdu_data,
    output logic          regf_we,
    output logic [AW-1:0] regf_din_addr,
    output logic [DW-1:0] regf_din,
    output logic          wb_fwd_valid,
    output logic [15:0]   wb_commit_cnt
);

    logic [2:0]    valid;
    logic [2:0]    gnt;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [15:0]   cnt_q, cnt_d;

    assign valid = {mdu_valid, lsu_valid, alu_valid};

`ifdef NCPU_WB_RR_EN
    logic [1:0] ptr_q, ptr_d;

    // First valid source in the order a, b, c wins.
    function automatic logic [2:0] pick3(input logic [2:0] v, input logic [1:0] a,
                                         input logic [1:0] b, input logic [1:0] c);
        logic [2:0] g;
        g = '0;
        if (v[a])      g[a] = 1'b1;
        else if (v[b]) g[b] = 1'b1;
        else if (v[c]) g[c] = 1'b1;
        return g;
    endfunction

    // Round-robin grant: search starts just after the last granted source.
    always_comb begin
        gnt = '0;
        if (!rst && !flush) begin
            case (ptr_q)
                2'd0:    gnt = pick3(valid, 2'd1, 2'd2, 2'd0);
                2'd1:    gnt = pick3(valid, 2'd2, 2'd0, 2'd1);
                default: gnt = pick3(valid, 2'd0, 2'd1, 2'd2);
            endcase
        end
    end

    // Pointer moves only when something is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0])      ptr_d = 2'd0;
        else if (gnt[1]) ptr_d = 2'd1;
        else if (gnt[2]) ptr_d = 2'd2;
    end

    // Last-grant pointer; reset value 2 makes ALU first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 2'd2;
        else     ptr_q <= ptr_d;
    end
`else
    // Fixed-priority grant: LSU, then MDU, then ALU.
    always_comb begin
        gnt = '0;
        if (!rst && !flush) begin
            if (valid[1])      gnt[1] = 1'b1;
            else if (valid[2]) gnt[2] = 1'b1;
            else if (valid[0]) gnt[0] = 1'b1;
        end
    end
`endif

    assign alu_ready = gnt[0];
    assign lsu_ready = gnt[1];
    assign mdu_ready = gnt[2];

    // Route the granted source's destination and value.
    always_comb begin
        sel_addr = alu_addr;
        sel_data = alu_data;
        if (gnt[1]) begin
            sel_addr = lsu_addr;
            sel_data = lsu_data;
        end else if (gnt[2]) begin
            sel_addr = mdu_addr;
            sel_data = mdu_data;
        end
    end

    // Next write-back register state; r0 is accepted and counted but never written.
    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (|gnt) begin
            we_d   = (sel_addr != '0);
            addr_d = sel_addr;
            data_d = sel_data;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
    end

    // Write-back output register and commit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign regf_we       = we_q;
    assign regf_din_addr = addr_q;
    assign regf_din      = data_q;
    assign wb_fwd_valid  = we_q;
    assign wb_commit_cnt = cnt_q;

endmodule
